// File: rtl/exec_stage_pkg.sv
// Shared constants and types for the execute stage: opcodes, widths, FSM states.
package exec_stage_pkg;

  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 3;
  localparam int MUL_ITERS = 8;
  localparam int CNT_W     = 4;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_SLT = 3'b100,
    OP_MUL = 3'b101,
    OP_SLL = 3'b110,
    OP_NOP = 3'b111
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/exec_stage_if.sv
// Issue/writeback bundle between the decode side, the execute stage and the register file.
interface exec_stage_if;
  import exec_stage_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [2:0]        op;
  logic [ADDR_W-1:0] rd;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              regwrite;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  logic              zero;
  logic              busy;

  modport master (
    output in_valid, op, rd, a, b,
    input  in_ready, regwrite, wa, wd, zero, busy
  );

  modport slave (
    input  in_valid, op, rd, a, b,
    output in_ready, regwrite, wa, wd, zero, busy
  );

endinterface

// File: rtl/exec_stage_mul8_seq.sv
// Shift-add 8x8 multiplier keeping the low 8 product bits; one iteration per clock, 8 iterations.
// o_done/o_product are valid during the last iteration cycle, so the caller registers them at the completing edge.
module mul8_seq
  import exec_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic              o_done,
  output logic [DATA_W-1:0] o_product
);

  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_mcand;
  logic [DATA_W-1:0] r_mplier;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] w_addend;
  logic [DATA_W-1:0] w_acc_nxt;

  assign w_addend  = r_mplier[0] ? r_mcand : '0;
  assign w_acc_nxt = r_acc + w_addend;
  assign o_done    = (r_cnt == CNT_W'(1));
  assign o_product = w_acc_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (i_start) begin
      r_cnt    <= CNT_W'(MUL_ITERS);
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_acc    <= '0;
    end else if (r_cnt != '0) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/exec_stage.sv
// Execute stage: single-cycle ALU ops write back one cycle after acceptance, MUL nine cycles after.
// in_ready drops for the 8 MUL iteration cycles; upstream holds its op until it is accepted.
module exec_stage
  import exec_stage_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  exec_stage_if.slave  bus
);

  state_e            r_state;
  state_e            w_state_nxt;
  op_e               w_op;
  logic [DATA_W-1:0] w_alu;
  logic              w_mul_start;
  logic              w_mul_done;
  logic [DATA_W-1:0] w_mul_product;
  logic              w_wr_en;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [DATA_W-1:0] w_wr_data;

  logic [ADDR_W-1:0] r_mul_rd;
  logic              r_regwrite;
  logic [ADDR_W-1:0] r_wa;
  logic [DATA_W-1:0] r_wd;
  logic              r_zero;

  assign w_op = op_e'(bus.op);

  always_comb begin
    w_alu = '0;
    case (w_op)
      OP_ADD:  w_alu = bus.a + bus.b;
      OP_SUB:  w_alu = bus.a - bus.b;
      OP_AND:  w_alu = bus.a & bus.b;
      OP_OR:   w_alu = bus.a | bus.b;
      OP_SLT:  w_alu = ($signed(bus.a) < $signed(bus.b)) ? DATA_W'(1) : '0;
      OP_SLL:  w_alu = bus.a << bus.b[2:0];
      default: w_alu = '0;
    endcase
  end

  mul8_seq u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_mul_start),
    .i_a       (bus.a),
    .i_b       (bus.b),
    .o_done    (w_mul_done),
    .o_product (w_mul_product)
  );

  // rd == 0 is the hardwired zero register: ops still run but never write back.
  always_comb begin
    w_state_nxt = r_state;
    w_mul_start = 1'b0;
    w_wr_en     = 1'b0;
    w_wr_addr   = r_wa;
    w_wr_data   = r_wd;
    case (r_state)
      ST_IDLE: begin
        if (bus.in_valid) begin
          if (w_op == OP_MUL) begin
            w_state_nxt = ST_MUL;
            w_mul_start = 1'b1;
          end else if (w_op != OP_NOP && bus.rd != '0) begin
            w_wr_en   = 1'b1;
            w_wr_addr = bus.rd;
            w_wr_data = w_alu;
          end
        end
      end
      ST_MUL: begin
        if (w_mul_done) begin
          w_state_nxt = ST_IDLE;
          if (r_mul_rd != '0) begin
            w_wr_en   = 1'b1;
            w_wr_addr = r_mul_rd;
            w_wr_data = w_mul_product;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_mul_rd   <= '0;
      r_regwrite <= 1'b0;
      r_wa       <= '0;
      r_wd       <= '0;
      r_zero     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_regwrite <= w_wr_en;
      if (w_mul_start) begin
        r_mul_rd <= bus.rd;
      end
      if (w_wr_en) begin
        r_wa   <= w_wr_addr;
        r_wd   <= w_wr_data;
        r_zero <= (w_wr_data == '0);
      end
    end
  end

  assign bus.in_ready = (r_state == ST_IDLE);
  assign bus.busy     = (r_state == ST_MUL);
  assign bus.regwrite = r_regwrite;
  assign bus.wa       = r_wa;
  assign bus.wd       = r_wd;
  assign bus.zero     = r_zero;

endmodule

// File: tb/tb_exec_stage.sv
// Directed bench for exec_stage: stimulus pushes expected writebacks, a negedge monitor checks them.
module tb_exec_stage;
  import exec_stage_pkg::*;

  typedef struct {
    logic [2:0] wa;
    logic [7:0] wd;
    logic       zero;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  exec_stage_if bus();

  exec_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Writeback monitor: every regwrite pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (bus.regwrite === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL wb_unexpected: got wa=%0d wd=%02h at cyc %0d, expected no write",
                 bus.wa, bus.wd, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.wa !== e.wa || bus.wd !== e.wd || bus.zero !== e.zero || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL wb_check: got wa=%0d wd=%02h zero=%0b cyc=%0d, expected wa=%0d wd=%02h zero=%0b cyc=%0d",
                   bus.wa, bus.wd, bus.zero, cyc, e.wa, e.wd, e.zero, e.cyc);
        end
      end
    end
  end

  // Called just after a negedge; returns after the accepting posedge.
  task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [7:0] a,
                       input logic [7:0] b, input bit wr, input logic [7:0] wd, input logic zero);
    int guard;
    exp_t e;
    bus.in_valid = 1'b1;
    bus.op = op;
    bus.rd = rd;
    bus.a  = a;
    bus.b  = b;
    guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 30) begin
      chk("issue_ready_timeout", 32'(guard), 32'd0);
    end
    if (wr) begin
      e.wa = rd;
      e.wd = wd;
      e.zero = zero;
      e.cyc = cyc + ((op == 3'b101) ? 9 : 1);
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  initial begin
    int stall;
    int guard;
    bus.in_valid = 1'b0;
    bus.op = 3'b111;
    bus.rd = '0;
    bus.a  = '0;
    bus.b  = '0;

    repeat (3) @(negedge clk);
    chk("rst_regwrite", 32'(bus.regwrite), 32'd0);
    chk("rst_wa",       32'(bus.wa),       32'd0);
    chk("rst_wd",       32'(bus.wd),       32'd0);
    chk("rst_zero",     32'(bus.zero),     32'd0);
    chk("rst_busy",     32'(bus.busy),     32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single-cycle ops back-to-back
    @(negedge clk); issue(3'b000, 3'd3, 8'hF0, 8'h20, 1, 8'h10, 1'b0);
    @(negedge clk); issue(3'b001, 3'd1, 8'h05, 8'h05, 1, 8'h00, 1'b1);
    @(negedge clk); issue(3'b100, 3'd2, 8'hFF, 8'h01, 1, 8'h01, 1'b0);
    @(negedge clk); issue(3'b010, 3'd4, 8'hF0, 8'h3C, 1, 8'h30, 1'b0);
    @(negedge clk); issue(3'b100, 3'd5, 8'h01, 8'hFF, 1, 8'h00, 1'b1);
    idle(2);

    // MUL with operands disturbed while iterating, then an op in the writeback cycle
    issue(3'b101, 3'd7, 8'h0D, 8'h0B, 1, 8'h8F, 1'b0);
    stall = 0;
    guard = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready === 1'b1 || guard > 20) break;
      if (stall == 0) chk("mul_busy", 32'(bus.busy), 32'd1);
      bus.in_valid = 1'b0;
      bus.a  = 8'hFF;
      bus.b  = 8'hFF;
      bus.rd = 3'd2;
      stall++;
      guard++;
    end
    chk("mul_stall_cycles", 32'(stall), 32'd8);
    issue(3'b000, 3'd4, 8'h01, 8'h01, 1, 8'h02, 1'b0);

    // ADD, OR, SLL, NOP on consecutive cycles
    @(negedge clk); issue(3'b000, 3'd5, 8'h03, 8'h04, 1, 8'h07, 1'b0);
    @(negedge clk); issue(3'b011, 3'd6, 8'h50, 8'h0A, 1, 8'h5A, 1'b0);
    @(negedge clk); issue(3'b110, 3'd1, 8'h81, 8'h09, 1, 8'h02, 1'b0);
    @(negedge clk); issue(3'b111, 3'd2, 8'h00, 8'h00, 0, 8'h00, 1'b0);

    // rd == 0 must neither write nor disturb zero/wa/wd
    @(negedge clk); issue(3'b001, 3'd3, 8'h07, 8'h07, 1, 8'h00, 1'b1);
    @(negedge clk); issue(3'b000, 3'd0, 8'h01, 8'h02, 0, 8'h00, 1'b0);
    idle(3);
    chk("hold_regwrite", 32'(bus.regwrite), 32'd0);
    chk("hold_wa",       32'(bus.wa),       32'd3);
    chk("hold_wd",       32'(bus.wd),       32'h00);
    chk("hold_zero",     32'(bus.zero),     32'd1);

    // Reset during the 4th MUL iteration aborts it
    @(negedge clk); issue(3'b000, 3'd6, 8'h40, 8'h02, 1, 8'h42, 1'b0);
    @(negedge clk); issue(3'b101, 3'd6, 8'h03, 8'h05, 0, 8'h0F, 1'b0);
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_regwrite", 32'(bus.regwrite), 32'd0);
    chk("abort_wa",       32'(bus.wa),       32'd0);
    chk("abort_wd",       32'(bus.wd),       32'd0);
    chk("abort_zero",     32'(bus.zero),     32'd0);
    chk("abort_busy",     32'(bus.busy),     32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(bus.in_ready), 32'd1);
    issue(3'b000, 3'd5, 8'h10, 8'h22, 1, 8'h32, 1'b0);
    idle(12);

    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("pending_writes", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/exec_stage.md
EXEC_STAGE -- requirements
Module: exec_stage

Interface
REQ-001 clk  input  1  single clock; all state updates on posedge clk.
REQ-002 rst_n  input  1  reset, asynchronous and active-low.
REQ-003 in_valid  input  1  operation presented this cycle.
REQ-004 in_ready  output  1  stage can accept; an operation is accepted at a posedge where in_valid and in_ready are both 1.
REQ-005 op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT, 101 MUL, 110 SLL, 111 NOP.
REQ-006 rd  input  3  destination register address for the result.
REQ-007 a  input  8  operand A, driven from register-file read port 1.
REQ-008 b  input  8  operand B, driven from register-file read port 2.
REQ-009 regwrite  output  1  one-cycle write strobe to the register file.
REQ-010 wa  output  3  write address to the register file.
REQ-011 wd  output  8  write data to the register file.
REQ-012 zero  output  1  1 when the last written-back wd was 8'h00.
REQ-013 busy  output  1  1 while a MUL is iterating.

Function
REQ-014 States SHALL be IDLE and MUL; in_ready = (state == IDLE), busy = (state == MUL).
REQ-015 All outputs SHALL be registered; regwrite, wa, wd and zero SHALL change only on posedge clk or on reset.
REQ-016 A single-cycle op (ADD, SUB, AND, OR, SLT, SLL) accepted at edge N SHALL assert regwrite for exactly the cycle following edge N, with wa = rd and wd = result.
REQ-017 Arithmetic SHALL be 8-bit modulo 2^8: ADD = a+b, SUB = a-b; carries and borrows SHALL be discarded.
REQ-018 SLT SHALL produce 8'h01 if signed(a) < signed(b), else 8'h00.
REQ-019 SLL SHALL produce a << b[2:0]; b[7:3] SHALL be ignored.
REQ-020 MUL accepted at edge N SHALL enter MUL and run one shift-add iteration per edge N+1..N+8; it SHALL assert regwrite in the cycle after edge N+8 with wd = low 8 bits of a*b, then return to IDLE.
REQ-021 MUL SHALL capture a, b and rd at acceptance; input changes during MUL SHALL NOT affect the result.
REQ-022 Single-cycle ops SHALL be accepted back-to-back, one per cycle; a new op SHALL be accepted in the same cycle as a MUL writeback strobe.
REQ-023 NOP, and any op with rd == 0, SHALL complete with its normal latency, SHALL NOT assert regwrite, and SHALL NOT update zero.
REQ-024 When regwrite is 0, wa and wd SHALL hold their previous values.
REQ-025 in_valid while in_ready == 0 SHALL be ignored; upstream holds the op.

Reset
REQ-026 rst_n low SHALL immediately force: state IDLE, regwrite 0, wa 0, wd 0, zero 0, busy 0, and iteration counter 0.
REQ-027 Reset asserted during MUL SHALL abort the operation with no writeback; the first edge after release SHALL be able to accept a new op.

Structure
REQ-028 A shared package SHALL hold the opcode constants, data width 8, and register address width 3.
REQ-029 The iterative multiplier SHALL be a sub-module mul8_seq with start, done, 8-bit operands and 8-bit product.
REQ-030 The operation state machine and the single-cycle ALU SHALL remain in exec_stage.

Verification
REQ-031 ADD a=8'hF0, b=8'h20, rd=3 -> next cycle regwrite=1, wa=3, wd=8'h10, zero=0.
REQ-032 SUB a=5, b=5, rd=1 -> wd=8'h00, zero=1; then SLT a=8'hFF, b=8'h01 -> wd=8'h01.
REQ-033 MUL a=8'h0D, b=8'h0B, rd=7 at edge N -> in_ready=0 for 8 cycles, regwrite only in the cycle after edge N+8, wd=8'h8F; operands changed mid-MUL have no effect.
REQ-034 Back-to-back ADD, OR, SLL (b=8'h09, shift 1), NOP on consecutive cycles -> three consecutive regwrite pulses, then none for the NOP.
REQ-035 ADD with rd=0 -> no regwrite; rst_n low at iteration 4 of a MUL -> no regwrite, all outputs 0, next op accepted after release.
